// File: rtl/dffmem_pkg.sv
// Shared types and defaults for the burst flip-flop RAM.
//   state_e     : controller states (IDLE, WRITE, READ)
//   DEF_DATA_W  : default word width in bits
//   DEF_ADDR_W  : default address width (depth = 2**ADDR_W)
//   be_width()  : number of byte enables for a given word width
package dffmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 3;

    function automatic int unsigned be_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dffmem_array.sv
// DEPTH x DATA_W flip-flop storage, cleared by reset.
//   clk, rst    : clock, asynchronous active-high clear
//   we          : write strobe for this cycle
//   waddr/wbe   : write word address and per-byte enables
//   wdata       : write data
//   raddr       : read address
//   rd_word_c   : combinational read data for raddr
module dffmem_array
    import dffmem_pkg::*;
#(
    parameter  int unsigned DATA_W = DEF_DATA_W,
    parameter  int unsigned ADDR_W = DEF_ADDR_W,
    localparam int unsigned BE_W   = be_width(DATA_W),
    localparam int unsigned DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [BE_W-1:0]   wbe,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rd_word_c
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Merge enabled bytes of the write beat into the addressed word.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (wbe[i]) begin
                    mem_d[waddr][8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < int'(DEPTH); j++) begin
                mem_q[j] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_word_c = mem_q[raddr];

endmodule

// File: rtl/dffmem_burst.sv
// Burst-capable flip-flop RAM with valid/ready command, write and read channels.
//   cmd_*  : burst command (direction, start address, beats minus one)
//   wr_*   : write beats with byte enables
//   rd_*   : registered, back-pressurable read beats
//   busy   : high whenever a burst is in progress
module dffmem_burst
    import dffmem_pkg::*;
#(
    parameter  int unsigned DATA_W = DEF_DATA_W,
    parameter  int unsigned ADDR_W = DEF_ADDR_W,
    localparam int unsigned BE_W   = be_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              wr_ready_q, wr_ready_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;

    logic              cmd_fire, wr_fire, rd_fire;
    logic              mem_we;
    logic [ADDR_W-1:0] ptr_next;
    logic [ADDR_W-1:0] raddr_c;
    logic [DATA_W-1:0] rd_word_c;

    assign cmd_fire = cmd_valid && cmd_ready_q;
    assign wr_fire  = wr_valid  && wr_ready_q;
    assign rd_fire  = rd_ready  && rd_valid_q;
    assign ptr_next = ptr_q + ADDR_W'(1);

    // IDLE prefetches the start word; READ prefetches the word after the current beat.
    assign raddr_c = (state_q == IDLE) ? cmd_addr : ptr_next;

    dffmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .we        (mem_we),
        .waddr     (ptr_q),
        .wbe       (wr_be),
        .wdata     (wr_data),
        .raddr     (raddr_c),
        .rd_word_c (rd_word_c)
    );

    // Next-state, pointer/count and read-data logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    ptr_d = cmd_addr;
                    cnt_d = cmd_len;
                    if (cmd_write) begin
                        state_d = WRITE;
                    end else begin
                        state_d   = READ;
                        rd_data_d = rd_word_c;
                    end
                end
            end
            WRITE: begin
                if (wr_fire) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_next;
                    cnt_d  = cnt_q - ADDR_W'(1);
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            READ: begin
                if (rd_fire) begin
                    if (cnt_q != '0) begin
                        ptr_d     = ptr_next;
                        cnt_d     = cnt_q - ADDR_W'(1);
                        rd_data_d = rd_word_c;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs are registered copies of the next state.
        cmd_ready_d = (state_d == IDLE);
        wr_ready_d  = (state_d == WRITE);
        rd_valid_d  = (state_d == READ);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            rd_data_q   <= '0;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            rd_data_q   <= rd_data_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dffmem_burst.sv
// Bench for dffmem_burst: a 16x8 instance and a 32x16 instance share the stimulus
// buses; sel steers handshakes and output observation to one of them.
module tb_dffmem_burst;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        cmd_valid, cmd_write;
    logic [3:0]  cmd_addr, cmd_len;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_ready;

    logic        cmd_ready0, wr_ready0, rd_valid0, busy0;
    logic [15:0] rd_data0;
    logic        cmd_ready1, wr_ready1, rd_valid1, busy1;
    logic [31:0] rd_data1;

    logic        cmd_ready_m, wr_ready_m, rd_valid_m, busy_m;
    logic [31:0] rd_data_m;

    assign cmd_ready_m = sel ? cmd_ready1 : cmd_ready0;
    assign wr_ready_m  = sel ? wr_ready1  : wr_ready0;
    assign rd_valid_m  = sel ? rd_valid1  : rd_valid0;
    assign busy_m      = sel ? busy1      : busy0;
    assign rd_data_m   = sel ? rd_data1   : {16'h0000, rd_data0};

    dffmem_burst u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid & ~sel),
        .cmd_ready (cmd_ready0),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr[2:0]),
        .cmd_len   (cmd_len[2:0]),
        .wr_valid  (wr_valid & ~sel),
        .wr_ready  (wr_ready0),
        .wr_data   (wr_data[15:0]),
        .wr_be     (wr_be[1:0]),
        .rd_valid  (rd_valid0),
        .rd_ready  (rd_ready & ~sel),
        .rd_data   (rd_data0),
        .busy      (busy0)
    );

    dffmem_burst #(.DATA_W(32), .ADDR_W(4)) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid & sel),
        .cmd_ready (cmd_ready1),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid & sel),
        .wr_ready  (wr_ready1),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_valid  (rd_valid1),
        .rd_ready  (rd_ready & sel),
        .rd_data   (rd_data1),
        .busy      (busy1)
    );

    typedef struct {
        bit          sel;
        bit          wr;
        logic [3:0]  addr;
        logic [3:0]  len;
        logic [31:0] data;   // write: beat k carries data+k
        logic [3:0]  be;
        logic [31:0] exp;    // read: expected first beat
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] model [2][16];
    logic [31:0] exp_q [$];
    int          checks;
    int          failures;
    int          m_ptr;

    function automatic int depth_of(input bit s);
        return s ? 16 : 8;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                model[s][a] = 32'h0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready_m), 32'd1);
        chk({tag, "_wr_ready"},  32'(wr_ready_m),  32'd0);
        chk({tag, "_rd_valid"},  32'(rd_valid_m),  32'd0);
        chk({tag, "_busy"},      32'(busy_m),      32'd0);
        chk({tag, "_rd_data"},   rd_data_m,        32'd0);
    endtask

    // Offer a command and hold it until accepted; returns #1 after the accept edge.
    task automatic send_cmd(input vec_t v);
        int n;
        sel       = v.sel;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready_m && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready_m), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic write_beats(input int n, input logic [31:0] base, input logic [3:0] be);
        int w;
        int bew;
        bew = sel ? 4 : 2;
        for (int k = 0; k < n; k++) begin
            wr_data  = base + 32'(k);
            wr_be    = be;
            wr_valid = 1'b1;
            w = 0;
            while (!wr_ready_m && w < 20) begin
                @(posedge clk); #1; w++;
            end
            chk("wr_ready_wait", 32'(wr_ready_m), 32'd1);
            @(posedge clk);
            for (int i = 0; i < bew; i++)
                if (be[i]) model[sel][m_ptr][8*i +: 8] = wr_data[8*i +: 8];
            m_ptr = (m_ptr + 1) % depth_of(sel);
            #1;
        end
        wr_valid = 1'b0;
    endtask

    task automatic read_beats(input int n);
        int w;
        rd_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (!rd_valid_m && w < 20) begin
                @(posedge clk); #1; w++;
            end
            chk("rd_valid_wait", 32'(rd_valid_m), 32'd1);
            chk("rd_beat", rd_data_m, exp_q.pop_front());
            @(posedge clk); #1;
        end
        rd_ready = 1'b0;
    endtask

    task automatic run_burst(input vec_t v);
        if (v.wr) begin
            send_cmd(v);
            m_ptr = int'(v.addr);
            write_beats(int'(v.len) + 1, v.data, v.be);
        end else begin
            for (int k = 0; k <= int'(v.len); k++)
                exp_q.push_back(model[v.sel][(int'(v.addr) + k) % depth_of(v.sel)]);
            send_cmd(v);
            chk("rd_latency", 32'(rd_valid_m), 32'd1);
            chk("rd_first", rd_data_m, v.exp);
            read_beats(int'(v.len) + 1);
        end
        chk("turn_cmd_ready", 32'(cmd_ready_m), 32'd1);
        chk("turn_busy", 32'(busy_m), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        logic [3:0] a;
        checks    = 0;
        failures  = 0;
        m_ptr     = 0;
        rst       = 1'b1;
        sel       = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        wr_be     = '0;
        rd_ready  = 1'b0;
        clear_model();

        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk_reset_outputs("reset");
        end
        sel = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        //             sel   wr    addr   len    data          be     exp first
        vecs[0]  = '{1'b0, 1'b0, 4'd5,  4'd0, 32'h0,        4'h0, 32'h0000};
        vecs[1]  = '{1'b0, 1'b1, 4'd7,  4'd0, 32'h1253,     4'h3, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 4'd7,  4'd0, 32'h0,        4'h0, 32'h1253};
        vecs[3]  = '{1'b0, 1'b1, 4'd2,  4'd0, 32'hAAAA,     4'h3, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 4'd2,  4'd0, 32'h5555,     4'h1, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 4'd2,  4'd0, 32'h0,        4'h0, 32'hAA55};
        vecs[6]  = '{1'b0, 1'b1, 4'd6,  4'd3, 32'h0001,     4'h3, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 4'd6,  4'd3, 32'h0,        4'h0, 32'h0001};
        vecs[8]  = '{1'b0, 1'b0, 4'd0,  4'd1, 32'h0,        4'h0, 32'h0003};
        vecs[9]  = '{1'b0, 1'b1, 4'd3,  4'd1, 32'h7777,     4'h0, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 4'd3,  4'd1, 32'h0,        4'h0, 32'h0000};
        vecs[11] = '{1'b1, 1'b1, 4'd14, 4'd3, 32'hDEADBEE0, 4'h5, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 4'd14, 4'd3, 32'h0,        4'h0, 32'h00AD00E0};
        vecs[13] = '{1'b1, 1'b0, 4'd0,  4'd1, 32'h0,        4'h0, 32'h00AD00E2};

        for (int i = 0; i < 14; i++)
            run_burst(vecs[i]);

        // Back-pressure: read addr 6 len 1 (holds 1, 2) stalled 3 cycles while a
        // second read command (addr 0, holds 3) waits on cmd_valid.
        sel       = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 4'd6;
        cmd_len   = 4'd1;
        cmd_valid = 1'b1;
        rd_ready  = 1'b0;
        @(posedge clk); #1;
        cmd_addr = 4'd0;
        cmd_len  = 4'd0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_rd_valid", 32'(rd_valid_m), 32'd1);
            chk("bp_rd_data", rd_data_m, 32'h0001);
            chk("bp_cmd_ready", 32'(cmd_ready_m), 32'd0);
            @(posedge clk); #1;
        end
        rd_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_beat2_valid", 32'(rd_valid_m), 32'd1);
        chk("bp_beat2_data", rd_data_m, 32'h0002);
        @(posedge clk); #1;
        chk("bp_end_valid", 32'(rd_valid_m), 32'd0);
        chk("bp_end_cmd_ready", 32'(cmd_ready_m), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("held_cmd_valid", 32'(rd_valid_m), 32'd1);
        chk("held_cmd_data", rd_data_m, 32'h0003);
        chk("held_cmd_busy", 32'(busy_m), 32'd1);
        @(posedge clk); #1;
        chk("held_cmd_done", 32'(rd_valid_m), 32'd0);
        @(posedge clk); #1;
        chk("held_cmd_once", 32'(busy_m), 32'd0);
        rd_ready = 1'b0;

        // Reset part-way through a 4-beat write on each instance.
        for (int s = 0; s < 2; s++) begin
            a  = (s == 1) ? 4'd15 : 4'd0;
            rv = '{1'(s), 1'b1, a, 4'd3, 32'h11111111, 4'hF, 32'h0};
            send_cmd(rv);
            m_ptr = int'(a);
            write_beats(2, 32'h11111111, 4'hF);
            chk("mid_busy", 32'(busy_m), 32'd1);
            rst = 1'b1;
            #1;
            chk_reset_outputs("mid_reset");
            clear_model();
            @(negedge clk) rst = 1'b0;
            @(posedge clk); #1;
            rv = '{1'(s), 1'b0, a, 4'd1, 32'h0, 4'h0, 32'h0};
            run_burst(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
